nn_stream_host: RTL
===================

Name: nn_stream_host

Overview:
- Host-side controller that drives the 4-4-2 MAC/ReLU inference pipeline from the other end of its interface.
- Accepts a narrow valid/ready byte-lane stream of 5-bit signed words and assembles the 4 inputs plus 24 weights into registers.
- Issues a one-cycle nn_in_ready pulse, waits for the pipeline's output-ready flags, captures out0/out1, and returns them on a 17-bit result stream.

Parameters:
- DW, 5, input/weight word width (signed).
- OUT_W, 17, result width (signed).
- TIMEOUT, 15, max cycles in WAIT before abort.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  load-stream word valid
- s_ready  out  1  load-stream ready
- s_data  in  DW  load-stream word (signed)
- nn_x  out  4*DW  x0..x3; x0 in LSBs
- nn_w_ih  out  16*DW  w04..w07,w14..w17,w24..w27,w34..w37; w04 in LSBs
- nn_w_ho  out  8*DW  w48,w49,w58,w59,w68,w69,w78,w79; w48 in LSBs
- nn_in_ready  out  1  pipeline launch pulse
- nn_out0  in  OUT_W  pipeline result 0
- nn_out1  in  OUT_W  pipeline result 1
- nn_out0_ready  in  1  pipeline result 0 valid
- nn_out1_ready  in  1  pipeline result 1 valid
- m_valid  out  1  result word valid
- m_ready  in  1  result consumer ready
- m_data  out  OUT_W  result word
- m_last  out  1  marks second (out1) result word
- busy  out  1  high in any state other than LOAD
- err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=1 at edge): state=LOAD, word counter=0, all nn_x/nn_w_* registers=0, result registers=0, err=0, timeout counter=0.
- During the rst cycle, s_ready=0, nn_in_ready=0, m_valid=0, m_last=0.
- Frame format is 28 words, in this order: x0..x3, then the nn_w_ih order, then the nn_w_ho order. Words are stored unchanged (signed pass-through).
- LOAD:
  - s_ready=1. Each s_valid&&s_ready beat writes word[cnt] and increments cnt.
  - Gaps in s_valid are allowed.
  - The beat with cnt=27 resets cnt to 0 and transitions to FIRE.
- FIRE:
  - Exactly one cycle with nn_in_ready=1.
  - nn_x/nn_w_* remain stable (no writes outside LOAD).
  - Next state is WAIT.
- WAIT:
  - Sample the network flags every cycle.
  - When nn_out0_ready&&nn_out1_ready, capture nn_out0/nn_out1 at that edge and go to SEND0.
  - The pipeline asserts the flags in cycle c+3 when FIRE is cycle c, so m_valid first rises in cycle c+4.
  - Timeout counter increments per WAIT cycle. If TIMEOUT cycles elapse without the flags, set err=1 (sticky until rst), emit no results, return to LOAD.
  - A single flag without the other is ignored (counts toward timeout).
- SEND0: m_valid=1, m_data=out0, m_last=0; hold until m_ready, then go to SEND1.
- SEND1: m_valid=1, m_data=out1, m_last=1; on m_ready, go to LOAD.
- m_data/m_valid/m_last stay stable while m_valid&&!m_ready.
- s_ready=0 in all non-LOAD states; the load stream is back-pressured during compute and send.
- Reset mid-frame discards partial words and starts the next frame at word 0.
- The nn_out_ready flags arriving outside WAIT are ignored.

Optional Feature:
- Macro NN_STREAM_HOST_WEIGHT_CACHE_EN.
- Defined:
  - Extra input port s_xonly (1 bit), sampled on the first beat of a frame (cnt=0).
  - If s_xonly=1, the frame is 4 words (x0..x3 only); cnt=3 triggers FIRE and the previously loaded weights are reused.
  - Weights after reset are 0.
- Undefined: port absent; every frame is 28 words.

Decomposition:
- Package nn_pkg holds:
  - DW, OUT_W, N_IN=4, N_HID=4, N_OUT=2, FRAME_WORDS=28, X_WORDS=4.
  - State enum {LOAD, FIRE, WAIT, SEND0, SEND1}.
  - Word-index base constants for the x, ih and ho segments.
- Sub-module nn_load_regfile holds the 28-entry indexed word store with write enable and flattened bus outputs. The FSM, timeout and result registers stay in the top module.

Test Plan:
- Frame of all 28 words = 1, m_ready=1: one nn_in_ready pulse, the cycle after the 28th beat; results 16 then 16 (m_last on the second); m_valid rises 4 cycles after the pulse.
- x0..x3 = -1, all weights = 1: hidden sums -4 are clamped by ReLU; results 0, 0.
- All words = -16 (extremes): hidden 1024 each; results -65536, -65536 with no overflow.
- m_ready held 0 for 10 cycles after m_valid: out0 is held stable; s_ready stays 0 throughout; a second frame is accepted only after m_last handshakes.
- nn_out0_ready/nn_out1_ready tied 0: err=1 after 15 WAIT cycles, no m_valid, s_ready returns to 1. Asserting rst then clears err.
- rst asserted after 10 beats: the next 28-beat frame of all 1s yields 16, 16. With the macro defined, a follow-up s_xonly frame of x=2 yields 32, 32.

Source files
------------

// File: rtl/nn_stream_host_pkg.sv
// nn_pkg: shared constants, frame layout and FSM state type for the
// nn_stream_host block (host-side loader/launcher for the 4-4-2 MAC/ReLU
// inference pipeline).
//
// Frame layout (one word per beat, word index = cnt):
//   [X_BASE  +: 4 ] x0..x3
//   [IH_BASE +: 16] w04..w07, w14..w17, w24..w27, w34..w37
//   [HO_BASE +: 8 ] w48, w49, w58, w59, w68, w69, w78, w79
package nn_pkg;

  localparam int DW          = 5;   // signed input/weight word width
  localparam int OUT_W       = 17;  // signed result width
  localparam int N_IN        = 4;
  localparam int N_HID       = 4;
  localparam int N_OUT       = 2;
  localparam int X_WORDS     = N_IN;
  localparam int FRAME_WORDS = N_IN + N_IN * N_HID + N_HID * N_OUT;  // 28
  localparam int TIMEOUT_DEF = 15;  // WAIT cycles before abort

  localparam int X_BASE  = 0;
  localparam int IH_BASE = X_BASE + X_WORDS;
  localparam int HO_BASE = IH_BASE + N_IN * N_HID;

  localparam int CNT_W = $clog2(FRAME_WORDS);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_FIRE,
    ST_WAIT,
    ST_SEND0,
    ST_SEND1
  } state_e;

endpackage

// File: rtl/nn_stream_host_if.sv
// nn_stream_host_if: load stream (words in) and result stream (results out)
// of nn_stream_host, bundled as one interface.
//   slave  : the nn_stream_host side (consumes s_*, produces m_*)
//   master : the feeder/consumer side (produces s_*, consumes m_*)
// Optional: NN_STREAM_HOST_WEIGHT_CACHE_EN adds s_xonly (x-only frame flag).
interface nn_stream_host_if;
  import nn_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    s_data;
`ifdef NN_STREAM_HOST_WEIGHT_CACHE_EN
  logic             s_xonly;
`endif
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic             m_last;

  modport slave (
    input  s_valid,
    input  s_data,
`ifdef NN_STREAM_HOST_WEIGHT_CACHE_EN
    input  s_xonly,
`endif
    output s_ready,
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport master (
    output s_valid,
    output s_data,
`ifdef NN_STREAM_HOST_WEIGHT_CACHE_EN
    output s_xonly,
`endif
    input  s_ready,
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/nn_stream_host_load_regfile.sv
// nn_load_regfile: 28-entry word store filled one word per load beat, exposed
// as the flattened x / input-hidden / hidden-output buses of the pipeline.
// Ports:
//   clk, rst  clock, synchronous active-high reset (clears every word)
//   we_i      write strobe (one accepted load beat)
//   idx_i     word index 0..27
//   wdata_i   word to store (signed, stored unchanged)
//   x_o       x0..x3, x0 in LSBs
//   w_ih_o    w04..w37, w04 in LSBs
//   w_ho_o    w48..w79, w48 in LSBs
module nn_load_regfile
  import nn_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we_i,
  input  logic [CNT_W-1:0]             idx_i,
  input  logic [DW-1:0]                wdata_i,
  output logic [N_IN*DW-1:0]           x_o,
  output logic [N_IN*N_HID*DW-1:0]     w_ih_o,
  output logic [N_HID*N_OUT*DW-1:0]    w_ho_o
);

  logic [FRAME_WORDS-1:0][DW-1:0] words_q;

  // NOTE: the store is tiny and must read back as zero after reset, so every
  // entry is reset; larger memories would normally be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
    end else if (we_i) begin
      for (int i = 0; i < FRAME_WORDS; i++) begin
        if (idx_i == CNT_W'(i)) words_q[i] <= wdata_i;
      end
    end
  end

  assign x_o    = words_q[X_BASE  +: X_WORDS];
  assign w_ih_o = words_q[IH_BASE +: N_IN * N_HID];
  assign w_ho_o = words_q[HO_BASE +: N_HID * N_OUT];

endmodule

// File: rtl/nn_stream_host.sv
// nn_stream_host: loads a frame of x/weight words from the load stream,
// launches the 4-4-2 pipeline with a one-cycle nn_in_ready pulse, waits for
// both result flags (bounded by TIMEOUT), and returns out0 then out1 on the
// result stream (m_last on out1).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bus (slave)         s_valid/s_ready/s_data load stream,
//                       m_valid/m_ready/m_data/m_last result stream
//   nn_x, nn_w_ih, nn_w_ho   stored frame words to the pipeline
//   nn_in_ready         launch pulse (FIRE state)
//   nn_out0/1, nn_out0/1_ready   pipeline results and their valid flags
//   busy                high outside LOAD
//   err                 sticky WAIT timeout flag
// Optional: NN_STREAM_HOST_WEIGHT_CACHE_EN enables 4-word x-only frames
// (bus.s_xonly sampled on word 0) that reuse the stored weights.
module nn_stream_host
  import nn_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  nn_stream_host_if.slave            bus,
  output logic [N_IN*DW-1:0]         nn_x,
  output logic [N_IN*N_HID*DW-1:0]   nn_w_ih,
  output logic [N_HID*N_OUT*DW-1:0]  nn_w_ho,
  output logic                       nn_in_ready,
  input  logic [OUT_W-1:0]           nn_out0,
  input  logic [OUT_W-1:0]           nn_out1,
  input  logic                       nn_out0_ready,
  input  logic                       nn_out1_ready,
  output logic                       busy,
  output logic                       err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [OUT_W-1:0] out0_q, out0_d, out1_q, out1_d;
  logic             err_q, err_d;

  logic beat, last_beat, flags_both, timeout_hit;

  // s_ready is only ever high in LOAD, so a beat implies LOAD.
  assign beat        = bus.s_valid && bus.s_ready;
  assign flags_both  = nn_out0_ready && nn_out1_ready;
  assign timeout_hit = (state_q == ST_WAIT) && !flags_both
                       && (to_cnt_q == TO_W'(TIMEOUT - 1));

`ifdef NN_STREAM_HOST_WEIGHT_CACHE_EN
  logic xonly_q, xonly_now;

  // On word 0 the flag comes straight from the bus; later words use the copy.
  assign xonly_now = (cnt_q == '0) ? bus.s_xonly : xonly_q;
  assign last_beat = beat
                     && (cnt_q == CNT_W'(xonly_now ? X_WORDS - 1 : FRAME_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst)                        xonly_q <= 1'b0;
    else if (beat && cnt_q == '0)   xonly_q <= bus.s_xonly;
  end
`else
  assign last_beat = beat && (cnt_q == CNT_W'(FRAME_WORDS - 1));
`endif

  nn_load_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (beat),
    .idx_i   (cnt_q),
    .wdata_i (bus.s_data),
    .x_o     (nn_x),
    .w_ih_o  (nn_w_ih),
    .w_ho_o  (nn_w_ho)
  );

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (last_beat)        state_d = ST_FIRE;
      ST_FIRE:                        state_d = ST_WAIT;
      ST_WAIT:  if (flags_both)       state_d = ST_SEND0;
                else if (timeout_hit) state_d = ST_LOAD;
      ST_SEND0: if (bus.m_ready)      state_d = ST_SEND1;
      ST_SEND1: if (bus.m_ready)      state_d = ST_LOAD;
      default:                        state_d = ST_LOAD;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Handshake outputs are forced low while rst is asserted.
  always_comb begin
    bus.s_ready = 1'b0;
    nn_in_ready = 1'b0;
    bus.m_valid = 1'b0;
    bus.m_last  = 1'b0;
    bus.m_data  = out0_q;
    busy        = (state_q != ST_LOAD);
    if (!rst) begin
      case (state_q)
        ST_LOAD:  bus.s_ready = 1'b1;
        ST_FIRE:  nn_in_ready = 1'b1;
        ST_SEND0: bus.m_valid = 1'b1;
        ST_SEND1: begin
          bus.m_valid = 1'b1;
          bus.m_last  = 1'b1;
          bus.m_data  = out1_q;
        end
        default: ;
      endcase
    end
  end

  // ---------------- word counter, timeout, results, err ----------------
  always_comb begin
    cnt_d    = cnt_q;
    to_cnt_d = '0;
    out0_d   = out0_q;
    out1_d   = out1_q;
    err_d    = err_q;
    if (beat) cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
    if (state_q == ST_WAIT) begin
      if (flags_both) begin
        out0_d = nn_out0;
        out1_d = nn_out1;
      end else if (timeout_hit) begin
        err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      to_cnt_q <= '0;
      out0_q   <= '0;
      out1_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      to_cnt_q <= to_cnt_d;
      out0_q   <= out0_d;
      out1_q   <= out1_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;

endmodule
